// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with byte-lane writes,
// programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int Trans_Width = 2,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [ADDRWIDTH-1:0]   HADDR,
  input  logic [Trans_Width-1:0] HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [DATAWIDTH-1:0]   HWDATA,
  input  logic                   HREADY,
  output logic [DATAWIDTH-1:0]   HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP
);

  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int NB   = DATAWIDTH / 8;
  localparam int CNTW = 4;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;

  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  logic          accept;
  logic          oob, bad_size, misal, illegal;
  logic [NB-1:0] be;

  // Only the transfer-type MSB matters: NONSEQ/SEQ start a transfer.
  logic unused_htrans;
  assign unused_htrans = ^HTRANS[Trans_Width-2:0];

  assign accept   = HSEL & HREADY & HTRANS[Trans_Width-1];
  // Any address bit above the word index makes the access out of range.
  assign oob      = |HADDR[ADDRWIDTH-1:IDXW+2];
  assign bad_size = (HSIZE > 3'b010);
  assign misal    = ((HSIZE == 3'b001) && HADDR[0]) ||
                    ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign illegal  = oob | bad_size | misal;

  // State and latched address-phase control.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Next state: WAIT counts down, ERR1 always to ERR2, IDLE/DATA/ERR2 may start a new transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = HADDR[IDXW+1:2];
          lane_d  = HADDR[1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
    endcase
  end

  // Little-endian byte enables from the latched size and low address bits.
  always_comb begin
    be = '0;
    case (size_q)
      3'b000:  be = NB'(1) << lane_q;
      3'b001:  be = lane_q[1] ? NB'(4'b1100) : NB'(4'b0011);
      default: be = '1;
    endcase
  end

  // Write commit at the end of the DATA cycle; unselected lanes keep their bytes.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three responders (0, 3 and 2 wait states) on a shared bus,
// each HREADY looped back from its own HREADYOUT as the bus mux would.
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, DW = 3'b011;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  int          dsel = 0;
  logic        sel = 1'b0;
  logic [1:0]  htrans = IDL;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = W;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [2:0]  hsel;
  logic        hro [3];
  logic        hrs [3];
  logic [31:0] hrd [3];

  int applied = 0;
  int miscompares = 0;

  always_comb begin
    hsel = '0;
    for (int k = 0; k < 3; k++) hsel[k] = sel && (dsel == k);
  end

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[0]),
    .HRDATA(hrd[0]), .HREADYOUT(hro[0]), .HRESP(hrs[0]));

  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[1]),
    .HRDATA(hrd[1]), .HREADYOUT(hro[1]), .HRESP(hrs[1]));

  ahb_lite_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[2]),
    .HRDATA(hrd[2]), .HREADYOUT(hro[2]), .HRESP(hrs[2]));

  // One bus cycle: address phase of the next transfer plus HWDATA of the
  // current data phase, and the response expected during that same cycle.
  typedef struct {
    string       nm;
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic        rsp;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string nm, input logic s, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy, input logic rsp, input logic [31:0] rd);
    vec_t v;
    v.nm = nm; v.sel = s; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
    v.rdy = rdy; v.rsp = rsp; v.rd = rd;
    tv.push_back(v);
  endtask

  task automatic drive(input int d, input logic s, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(negedge HCLK);
    dsel = d; sel = s; htrans = tr; hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
    #1;
  endtask

  task automatic check(input string nm, input int d, input logic rdy, input logic rsp,
                       input logic [31:0] rd);
    applied++;
    if (hro[d] !== rdy || hrs[d] !== rsp || hrd[d] !== rd) begin
      miscompares++;
      $display("FAIL %s (dut%0d): got rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
               nm, d, hro[d], hrs[d], hrd[d], rdy, rsp, rd);
    end
  endtask

  initial begin
    //  name        sel tr   wr  sz  addr     hwdata        rdy rsp rdata
    add("idle0",    0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h0);
    add("wr04_a",   1, NS,  1, W, 32'h004, 32'h0,          1, 0, 32'h0);
    add("wr10_a",   1, NS,  1, W, 32'h010, 32'h11223344,   1, 0, 32'h0);
    add("rd10_a",   1, NS,  0, W, 32'h010, 32'hDEADBEEF,   1, 0, 32'h0);
    add("rd10_d",   0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'hDEADBEEF);
    add("wr20_a",   1, NS,  1, W, 32'h020, 32'h0,          1, 0, 32'h0);
    add("wb22_a",   1, NS,  1, B, 32'h022, 32'h00000000,   1, 0, 32'h0);
    add("wh20_a",   1, NS,  1, H, 32'h020, 32'hFFABFFFF,   1, 0, 32'h0);
    add("rd20_a",   1, NS,  0, W, 32'h020, 32'hFFFF1234,   1, 0, 32'h0);
    add("rd04_seq", 1, SQ,  0, W, 32'h004, 32'h0,          1, 0, 32'h00AB1234);
    add("rd04_d",   0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h11223344);
    add("oob_a",    1, NS,  0, W, 32'h400, 32'h0,          1, 0, 32'h0);
    add("oob_e1",   0, IDL, 0, W, 32'h000, 32'h0,          0, 1, 32'h0);
    add("mis06_a",  1, NS,  1, W, 32'h006, 32'h0,          1, 1, 32'h0);
    add("mis06_e1", 0, IDL, 0, W, 32'h000, 32'hCAFEF00D,   0, 1, 32'h0);
    add("mish_a",   1, NS,  0, H, 32'h021, 32'h0,          1, 1, 32'h0);
    add("mish_e1",  0, IDL, 0, W, 32'h000, 32'h0,          0, 1, 32'h0);
    add("size_a",   1, NS,  0, DW, 32'h010, 32'h0,         1, 1, 32'h0);
    add("size_e1",  0, IDL, 0, W, 32'h000, 32'h0,          0, 1, 32'h0);
    add("rd04b_a",  1, NS,  0, W, 32'h004, 32'h0,          1, 1, 32'h0);
    add("rd04b_d",  0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h11223344);
    add("nosel",    0, NS,  1, W, 32'h010, 32'h0,          1, 0, 32'h0);
    add("busy",     1, BSY, 1, W, 32'h010, 32'h0BADF00D,   1, 0, 32'h0);
    add("idle_sel", 1, IDL, 1, W, 32'h010, 32'h0BADF00D,   1, 0, 32'h0);
    add("rd10b_a",  1, NS,  0, W, 32'h010, 32'h0BADF00D,   1, 0, 32'h0);
    add("rd10b_d",  0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'hDEADBEEF);
    add("wb23_a",   1, NS,  1, B, 32'h023, 32'h0,          1, 0, 32'h0);
    add("rd20b_a",  1, NS,  0, W, 32'h020, 32'h5A000000,   1, 0, 32'h0);
    add("rd20b_d",  0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h5AAB1234);
    add("wr3fc_a",  1, NS,  1, W, 32'h3FC, 32'h0,          1, 0, 32'h0);
    add("rd3fc_a",  1, NS,  0, W, 32'h3FC, 32'h89ABCDEF,   1, 0, 32'h0);
    add("rd3fc_d",  0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h89ABCDEF);
    add("wh3fe_a",  1, NS,  1, H, 32'h3FE, 32'h0,          1, 0, 32'h0);
    add("rd3fcb_a", 1, NS,  0, W, 32'h3FC, 32'h77770000,   1, 0, 32'h0);
    add("rd3fcb_d", 0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h7777CDEF);
    add("idle_end", 0, IDL, 0, W, 32'h000, 32'h0,          1, 0, 32'h0);

    // Reset state of every responder.
    repeat (2) @(negedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) check("reset_state", k, 1'b1, 1'b0, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Zero-wait responder: table of pipelined transfers.
    foreach (tv[i]) begin
      drive(0, tv[i].sel, tv[i].tr, tv[i].wr, tv[i].sz, tv[i].a, tv[i].wd);
      check(tv[i].nm, 0, tv[i].rdy, tv[i].rsp, tv[i].rd);
    end

    // Three wait states: write 0x30, then a read held until HREADY returns.
    drive(1, 1, NS, 1, W, 32'h30, 32'h0);
    check("ws3_wr_addr", 1, 1, 0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 1, NS, 0, W, 32'h30, 32'h55AA55AA);
      check("ws3_wr_wait", 1, 0, 0, 32'h0);
    end
    drive(1, 1, NS, 0, W, 32'h30, 32'h55AA55AA);
    check("ws3_wr_data", 1, 1, 0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, IDL, 0, W, 32'h0, 32'h0);
      check("ws3_rd_wait", 1, 0, 0, 32'h0);
    end
    drive(1, 0, IDL, 0, W, 32'h0, 32'h0);
    check("ws3_rd_data", 1, 1, 0, 32'h55AA55AA);
    drive(1, 0, IDL, 0, W, 32'h0, 32'h0);
    check("ws3_idle", 1, 1, 0, 32'h0);

    // Two wait states: preload 0x40, then reset in the middle of an overwrite.
    drive(2, 1, NS, 1, W, 32'h40, 32'h0);
    check("ws2_pre_addr", 2, 1, 0, 32'h0);
    for (int n = 0; n < 2; n++) begin
      drive(2, 0, IDL, 0, W, 32'h0, 32'h13572468);
      check("ws2_pre_wait", 2, 0, 0, 32'h0);
    end
    drive(2, 0, IDL, 0, W, 32'h0, 32'h13572468);
    check("ws2_pre_data", 2, 1, 0, 32'h0);
    drive(2, 1, NS, 1, W, 32'h40, 32'h0);
    check("ws2_ovw_addr", 2, 1, 0, 32'h0);
    drive(2, 0, IDL, 0, W, 32'h0, 32'hFFFFFFFF);
    check("ws2_ovw_wait", 2, 0, 0, 32'h0);
    HRESET = 1'b1;
    #1;
    check("ws2_async_rst", 2, 1, 0, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(2, 1, NS, 0, W, 32'h40, 32'hFFFFFFFF);
    check("ws2_rd_addr", 2, 1, 0, 32'h0);
    for (int n = 0; n < 2; n++) begin
      drive(2, 0, IDL, 0, W, 32'h0, 32'h0);
      check("ws2_rd_wait", 2, 0, 0, 32'h0);
    end
    drive(2, 0, IDL, 0, W, 32'h0, 32'h0);
    check("ws2_rd_old", 2, 1, 0, 32'h13572468);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder (slave) for the bus carrying HADDR/HTRANS/HWDATA/HRDATA.
- Decodes master address/control phases, stores write data in an internal word-organised SRAM array, returns read data on HRDATA.
- Inserts programmable wait states and generates the two-cycle AHB-Lite ERROR response for illegal accesses.
- Sits behind the bus decoder/mux; HSEL comes from the decoder, HREADYOUT/HRDATA/HRESP return through the mux.

Parameters:
- DATAWIDTH, 32, data bus width in bits (fixed at 32 for this block).
- ADDRWIDTH, 32, address bus width.
- Trans_Width, 2, HTRANS width.
- MEM_DEPTH, 256, number of 32-bit words; power of 2.
- WAIT_STATES, 0, extra data-phase cycles per OKAY transfer (0..15).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDRWIDTH  byte address.
- HTRANS  in  Trans_Width  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  DATAWIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (muxed HREADYOUT of the active slave).
- HRDATA  out  DATAWIDTH  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async assert, sync release): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, latched control cleared. The memory array is not reset. Reset during a data phase drops the pending write with no commit.
- Address phase accepted only when HSEL & HREADY & HTRANS[1]=1 on a rising edge. On acceptance, latch HADDR, HWRITE, HSIZE.
- IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY: HREADYOUT=1, HRESP=0.
- Error conditions, checked at acceptance:
  - word index HADDR[ADDRWIDTH-1:2] >= MEM_DEPTH;
  - HSIZE > 010;
  - misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: accepted legal transfer -> DATA if WAIT_STATES=0, else WAIT (counter loads WAIT_STATES-1). Accepted illegal transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. A new accepted transfer in the same cycle (pipelined) goes to WAIT, DATA or ERR1 as from IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; a new accepted transfer is handled as from IDLE; otherwise -> IDLE.
  - Errored writes never modify memory; errored reads drive HRDATA=0.
- Write commit: on the DATA-state edge only. Byte lanes are little-endian:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  - Unselected bytes are preserved.
- Read: HRDATA = mem[latched word index] (full word, all lanes) while in DATA. HRDATA=0 in all other states.
- Back-to-back write then read of the same address: the read data phase follows the write commit edge, so it returns the new data with no extra stall.
- Latency: OKAY transfer data phase = 1 + WAIT_STATES cycles; ERROR = 2 cycles.

Test Plan:
- Reset: assert HRESET mid-WAIT (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; a later read of that address returns the old contents.
- Word write then read: write 0xDEADBEEF to 0x10, then NONSEQ read of 0x10 pipelined in the write's data phase (WAIT_STATES=0) -> HRDATA=0xDEADBEEF one cycle after the read address phase.
- Byte/halfword lanes: word 0x00000000 at 0x20, byte write 0xAB to 0x22, halfword write 0x1234 to 0x20 -> word read of 0x20 returns 0x00AB1234.
- Wait states (WAIT_STATES=3): single read -> HREADYOUT low for exactly 3 cycles, then high with valid data; master holds the next address for those 3 cycles and it is accepted only when HREADY=1.
- Errors: read 0x400 with MEM_DEPTH=256, and word write to 0x06 -> each gives HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; memory is unchanged.
- IDLE/BUSY and HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, no memory change, FSM stays IDLE.
